// File: rtl/mdu_ctrl.sv
// Multiply/divide unit sequencer with HI/LO registers and pipeline stall.
// Optional MDU_DIV0_HOLD_EN: divide by zero leaves HI/LO unchanged.
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        md_in_id,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {IDLE, RUN} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] rs_q, rs_d;
  logic [31:0] rt_q, rt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic [63:0] rs_ext, rt_ext, prod;
  logic        sgn, rs_neg, rt_neg;
  logic [31:0] a_abs, b_abs, q_abs, r_abs;
  logic [31:0] quo, rem;

  // op_q[0] selects the unsigned variant for both MULT and DIV
  always_comb begin
    sgn    = ~op_q[0];
    rs_ext = {{32{sgn & rs_q[31]}}, rs_q};
    rt_ext = {{32{sgn & rt_q[31]}}, rt_q};
    prod   = rs_ext * rt_ext;
    rs_neg = sgn & rs_q[31];
    rt_neg = sgn & rt_q[31];
    a_abs  = rs_neg ? -rs_q : rs_q;
    b_abs  = rt_neg ? -rt_q : rt_q;
    q_abs  = '0;
    r_abs  = '0;
    if (b_abs != '0) begin
      q_abs = a_abs / b_abs;
      r_abs = a_abs % b_abs;
    end
    quo = (rs_neg ^ rt_neg) ? -q_abs : q_abs;
    rem = rs_neg ? -r_abs : r_abs;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          unique case (op)
            3'd0, 3'd1: begin
              state_d = RUN;
              cnt_d   = 4'(MULT_CYCLES);
              op_d    = op[1:0];
              rs_d    = rs_val;
              rt_d    = rt_val;
            end
            3'd2, 3'd3: begin
              state_d = RUN;
              cnt_d   = 4'(DIV_CYCLES);
              op_d    = op[1:0];
              rs_d    = rs_val;
              rt_d    = rt_val;
            end
            3'd4:    hi_d = rs_val;
            3'd5:    lo_d = rs_val;
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = IDLE;
          if (!op_q[1]) begin
            {hi_d, lo_d} = prod;
          end else if (rt_q == '0) begin
`ifdef MDU_DIV0_HOLD_EN
            hi_d = hi_q;
`else
            lo_d = 32'hFFFF_FFFF;
            hi_d = rs_q;
`endif
          end else begin
            lo_d = quo;
            hi_d = rem;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy  = (state_q == RUN);
  assign stall = md_in_id & (busy | (start & (op <= 3'd3)));
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: checks results, latency, stall and reset.
// Follows MDU_DIV0_HOLD_EN for the divide-by-zero expectation.
module tb_mdu_ctrl;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset, start, md_in_id;
  logic [2:0]  op;
  logic [31:0] rs_val, rt_val;
  logic        busy, stall;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] sb[$];
  logic [31:0] m_hi, m_lo;

  always #5 clk = ~clk;

  mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs_val(rs_val), .rt_val(rt_val), .md_in_id(md_in_id),
    .busy(busy), .stall(stall), .hi(hi), .lo(lo)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: {hi,lo} after op, given the current model HI/LO
  function automatic logic [63:0] model(input logic [2:0] o,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb2, q, r;
    logic [63:0] p;
    model = {m_hi, m_lo};
    case (o)
      3'd0: begin
        sa = longint'($signed(a)); sb2 = longint'($signed(b));
        p = 64'(sa * sb2);
        model = p;
      end
      3'd1: model = {32'b0, a} * {32'b0, b};
      3'd2, 3'd3: begin
        if (b == 0) begin
`ifdef MDU_DIV0_HOLD_EN
          model = {m_hi, m_lo};
`else
          model = {a, 32'hFFFF_FFFF};
`endif
        end else begin
          if (o == 3'd2) begin
            sa = longint'($signed(a)); sb2 = longint'($signed(b));
          end else begin
            sa = longint'({32'b0, a}); sb2 = longint'({32'b0, b});
          end
          q = sa / sb2;
          r = sa % sb2;
          model = {r[31:0], q[31:0]};
        end
      end
      3'd4: model = {a, m_lo};
      3'd5: model = {m_hi, a};
      default: ;
    endcase
  endfunction

  task automatic run_op(input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic md,
                        input bit inject);
    logic [63:0] e;
    int n;
    int cyc;
    cyc = (o < 3'd2) ? MC : DC;
    e = model(o, a, b);
    {m_hi, m_lo} = e;
    if (o <= 3'd3) sb.push_back(e);
    start = 1'b1; op = o; rs_val = a; rt_val = b; md_in_id = md;
    #1;
    chk("stall_start", 64'(stall), 64'(md & (o <= 3'd3)));
    @(posedge clk); #1;
    start = 1'b0;
    rs_val = $urandom; rt_val = $urandom;
    if (o <= 3'd3) begin
      n = 0;
      while (busy && n < 40) begin
        chk("stall_busy", 64'(stall), 64'(md));
        if (inject && n == 1) begin
          start = 1'b1; op = 3'd0;
          rs_val = 32'h7; rt_val = 32'h9;
        end else begin
          start = 1'b0;
        end
        n++;
        @(posedge clk); #1;
      end
      start = 1'b0;
      chk("busy_len", 64'(n), 64'(cyc));
      chk("stall_after", 64'(stall), 64'd0);
      if (sb.size() > 0) chk("result", {hi, lo}, sb.pop_front());
      else chk("sb_empty", 64'd1, 64'd0);
    end else begin
      chk("busy_mt", 64'(busy), 64'd0);
      chk("hilo_mt", {hi, lo}, e);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = '0;
    rs_val = '0; rt_val = '0; md_in_id = 1'b1;
    m_hi = '0; m_lo = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);

    run_op(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b1, 1'b0);
    chk("mult_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
    chk("div_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(3'd3, 32'd7, 32'd2, 1'b0, 1'b0);
    chk("divu_const", {hi, lo}, {32'd1, 32'd3});
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
    run_op(3'd1, 32'h8000_0000, 32'd3, 1'b0, 1'b0);
    run_op(3'd4, 32'h1234_5678, 32'd0, 1'b1, 1'b0);
    chk("mthi_const", 64'(hi), 64'h1234_5678);
    run_op(3'd5, 32'hCAFE_F00D, 32'd0, 1'b1, 1'b0);
    run_op(3'd6, 32'hDEAD_BEEF, 32'd1, 1'b1, 1'b0);
    run_op(3'd7, 32'hDEAD_BEEF, 32'd1, 1'b0, 1'b0);
    run_op(3'd0, 32'd1000, 32'hFFFF_FFF6, 1'b1, 1'b1);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);

    start = 1'b1; op = 3'd2; rs_val = 32'd100; rt_val = 32'd7;
    md_in_id = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_busy4", 64'(busy), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_stall", 64'(stall), 64'd0);
    chk("abort_hilo", {hi, lo}, 64'd0);
    m_hi = '0; m_lo = '0;

    run_op(3'd3, 32'd9, 32'd0, 1'b1, 1'b0);
`ifdef MDU_DIV0_HOLD_EN
    chk("div0_const", {hi, lo}, 64'd0);
`else
    chk("div0_const", {hi, lo}, {32'd9, 32'hFFFF_FFFF});
`endif

    for (int i = 0; i < 8; i++) begin
      run_op(3'($urandom_range(0, 5)), $urandom, $urandom,
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
